// File: rtl/register_reader.sv
// register_reader
//   Read-back path of the PCA9685-compatible register file. Serves one byte
//   per request/valid/ack handshake from the 2048-bit register blob and
//   maintains the control (pointer) register with auto-increment/wrap rules.
//
//   Optional feature: define REGISTER_READER_SNAPSHOT_EN to capture a whole
//   4-byte LED group when its first byte is fetched, so that multi-byte LED
//   reads are coherent.
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   register_blob_i  register n at bits [n*8 +: 8], bit n*8 is the byte MSB
//   ptr_load_i       load pointer from ptr_value_i (highest priority)
//   ptr_value_i      new pointer value
//   auto_inc_i       MODE1.AI, sampled at ack
//   rd_req_i         transmitter requests the next byte (used in IDLE only)
//   rd_ack_i         transmitter consumed rd_data_o (used in VALID only)
//   rd_data_o        byte being served, updated only on the FETCH edge
//   rd_valid_o       rd_data_o valid and stable
//   ptr_o            current pointer
//   busy_o           high in FETCH or VALID
module register_reader (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [0:2047] register_blob_i,
  input  logic          ptr_load_i,
  input  logic [7:0]    ptr_value_i,
  input  logic          auto_inc_i,
  input  logic          rd_req_i,
  input  logic          rd_ack_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  output logic [7:0]    ptr_o,
  output logic          busy_o
);

  localparam logic [7:0] LED_BASE     = 8'h06;
  localparam logic [7:0] LED_LAST     = 8'h45;
  localparam logic [7:0] ALL_LED_BASE = 8'hFA;
  localparam logic [7:0] ALL_LED_LAST = 8'hFD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_fetch;
  logic        w_advance;
  logic [7:0]  r_ptr;
  logic [7:0]  r_data;
  logic [7:0]  w_ptr_inc;
  logic        w_readable;
  logic [7:0]  w_live_byte;
  logic [7:0]  w_fetch_byte;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    w_advance    = 1'b0;
    if (ptr_load_i) begin
      // A pointer load aborts any transaction: no fetch, no increment.
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (rd_req_i) w_state_next = S_FETCH;
        end
        S_FETCH: begin
          w_state_next = S_VALID;
          w_fetch      = 1'b1;
        end
        S_VALID: begin
          if (rd_ack_i) begin
            w_state_next = S_IDLE;
            w_advance    = auto_inc_i;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte source
  // ---------------------------------------------------------------------------
  // Reserved 0x46..0xF9 and write-only ALL_LED registers read as zero.
  assign w_readable  = !((r_ptr > LED_LAST) && (r_ptr < ALL_LED_BASE)) &&
                       !((r_ptr >= ALL_LED_BASE) && (r_ptr <= ALL_LED_LAST));
  assign w_live_byte = register_blob_i[{r_ptr, 3'b000} +: 8];

  // Auto-increment wraps to MODE1 after the last LED register and after 0xFF.
  assign w_ptr_inc = ((r_ptr == LED_LAST) || (r_ptr == 8'hFF)) ? '0 : r_ptr + 8'd1;

`ifdef REGISTER_READER_SNAPSHOT_EN
  logic [0:31] r_snap;
  logic [3:0]  r_snap_group;
  logic        r_snap_valid;
  logic        w_in_led;
  logic [5:0]  w_led_off;
  logic [3:0]  w_group;
  logic [1:0]  w_offset;
  logic        w_snap_hit;

  assign w_in_led   = (r_ptr >= LED_BASE) && (r_ptr <= LED_LAST);
  assign w_led_off  = 6'(r_ptr - LED_BASE);
  assign w_group    = w_led_off[5:2];
  assign w_offset   = w_led_off[1:0];
  assign w_snap_hit = w_in_led && r_snap_valid && (w_offset != 2'd0) &&
                      (w_group == r_snap_group);

  always_comb begin
    w_fetch_byte = '0;
    if (w_readable) begin
      if (w_snap_hit) w_fetch_byte = r_snap[{w_offset, 3'b000} +: 8];
      else            w_fetch_byte = w_live_byte;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_snap       <= '0;
      r_snap_group <= '0;
      r_snap_valid <= 1'b0;
    end else if (ptr_load_i) begin
      r_snap_valid <= 1'b0;
    end else if (w_fetch) begin
      if (w_in_led && (w_offset == 2'd0)) begin
        r_snap       <= register_blob_i[{r_ptr, 3'b000} +: 32];
        r_snap_group <= w_group;
        r_snap_valid <= 1'b1;
      end else if (!(w_in_led && (w_group == r_snap_group))) begin
        r_snap_valid <= 1'b0;
      end
    end
  end
`else
  assign w_fetch_byte = w_readable ? w_live_byte : '0;
`endif

  // ---------------------------------------------------------------------------
  // Pointer and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr  <= '0;
      r_data <= '0;
    end else begin
      if (ptr_load_i)     r_ptr <= ptr_value_i;
      else if (w_advance) r_ptr <= w_ptr_inc;
      if (w_fetch) r_data <= w_fetch_byte;
    end
  end

  assign rd_data_o  = r_data;
  assign rd_valid_o = (r_state == S_VALID);
  assign ptr_o      = r_ptr;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_register_reader.sv
module tb_register_reader;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [0:2047] blob = '0;
  logic          ptr_load = 1'b0;
  logic [7:0]    ptr_value = '0;
  logic          auto_inc = 1'b1;
  logic          rd_req = 1'b0;
  logic          rd_ack = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [7:0]    ptr;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mem [256];
  int         m_ptr = 0;
  bit         m_sv = 1'b0;
  int         m_sg = 0;
  logic [7:0] m_snap [4];
  logic [7:0] m_last = '0;

  register_reader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .register_blob_i (blob),
    .ptr_load_i      (ptr_load),
    .ptr_value_i     (ptr_value),
    .auto_inc_i      (auto_inc),
    .rd_req_i        (rd_req),
    .rd_ack_i        (rd_ack),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .ptr_o           (ptr),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input int a, input logic [7:0] v);
    mem[a] = v;
    blob[a*8 +: 8] = v;
  endtask

  // Byte the DUT should capture at the FETCH edge for the current pointer.
  task automatic model_fetch(output logic [7:0] e);
    int p, g, o;
    p = m_ptr;
    if (p >= 'h46 && p <= 'hF9)      e = 8'h00;
    else if (p >= 'hFA && p <= 'hFD) e = 8'h00;
    else                             e = mem[p];
`ifdef REGISTER_READER_SNAPSHOT_EN
    if (p >= 'h06 && p <= 'h45) begin
      g = (p - 6) / 4;
      o = (p - 6) % 4;
      if (o == 0) begin
        m_sv = 1'b1;
        m_sg = g;
        for (int k = 0; k < 4; k++) m_snap[k] = mem[p + k];
      end else if (m_sv && m_sg == g) begin
        e = m_snap[o];
      end else begin
        m_sv = 1'b0;
      end
    end else begin
      m_sv = 1'b0;
    end
`else
    g = 0; o = 0;
`endif
    m_last = e;
  endtask

  task automatic model_ack(input bit ai);
    if (ai) m_ptr = (m_ptr == 'h45 || m_ptr == 'hFF) ? 0 : m_ptr + 1;
  endtask

  task automatic load_ptr(input logic [7:0] v);
    @(negedge clk);
    ptr_load = 1'b1;
    ptr_value = v;
    @(negedge clk);
    ptr_load = 1'b0;
    m_ptr = int'(v);
    m_sv = 1'b0;
    check_eq("load_ptr", 32'(ptr), 32'(m_ptr));
  endtask

  task automatic do_read(input bit ai, input int hold, input bit poke, output logic [7:0] got);
    logic [7:0] e;
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check_eq("fetch_state", 32'({busy, rd_valid}), 32'h2);
    model_fetch(e);
    @(negedge clk);
    got = rd_data;
    check_eq("valid_rise", 32'(rd_valid), 32'h1);
    check_eq("data", 32'(rd_data), 32'(e));
    if (poke) set_reg(m_ptr, ~mem[m_ptr]);
    for (int i = 0; i < hold; i++) begin
      rd_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("valid_hold", 32'({rd_valid, rd_data}), 32'({1'b1, e}));
    end
    rd_req = 1'b0;
    rd_ack = 1'b1;
    auto_inc = ai;
    @(negedge clk);
    rd_ack = 1'b0;
    model_ack(ai);
    check_eq("ack_drop", 32'({rd_valid, busy}), 32'h0);
    check_eq("ptr_adv", 32'(ptr), 32'(m_ptr));
    check_eq("data_idle", 32'(rd_data), 32'(e));
  endtask

  // Start a read, then load the pointer during FETCH (stage 0) or VALID (stage 1).
  task automatic abort_read(input int stage, input logic [7:0] v, input bit ack, input bit req);
    logic [7:0] e;
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    if (stage == 1) begin
      model_fetch(e);
      @(negedge clk);
      check_eq("abort_valid", 32'({rd_valid, rd_data}), 32'({1'b1, e}));
    end
    ptr_load = 1'b1;
    ptr_value = v;
    rd_ack = ack;
    rd_req = req;
    auto_inc = 1'b1;
    @(negedge clk);
    ptr_load = 1'b0;
    rd_ack = 1'b0;
    rd_req = 1'b0;
    m_ptr = int'(v);
    m_sv = 1'b0;
    check_eq("abort_state", 32'({rd_valid, busy}), 32'h0);
    check_eq("abort_ptr", 32'(ptr), 32'(m_ptr));
    check_eq("abort_data", 32'(rd_data), 32'(m_last));
  endtask

  initial begin
    logic [7:0] got;
    int v, a;

    // Power-on register defaults
    for (int i = 0; i < 256; i++) set_reg(i, 8'h00);
    set_reg('h00, 8'h11);
    set_reg('h01, 8'h04);
    set_reg('h02, 8'hE2);
    set_reg('h03, 8'hE4);
    set_reg('h04, 8'hE8);
    set_reg('h05, 8'hE0);
    for (int g = 0; g < 16; g++) set_reg('h09 + 4 * g, 8'h10);
    set_reg('hFE, 8'h1E);

    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'({rd_data, rd_valid, ptr, busy}), 32'h0);
    rst_n = 1'b1;

    // Sequential reads from MODE1
    load_ptr(8'h00);
    do_read(1'b1, 0, 1'b0, got); check_eq("mode1", 32'(got), 32'h11);
    do_read(1'b1, 1, 1'b0, got); check_eq("mode2", 32'(got), 32'h04);
    do_read(1'b1, 0, 1'b0, got); check_eq("subadr1", 32'(got), 32'hE2);
    check_eq("ptr_after3", 32'(ptr), 32'h03);

    // Wrap after LED_15_OFF_H and after 0xFF
    load_ptr(8'h45);
    do_read(1'b1, 0, 1'b0, got); check_eq("led15_off_h", 32'(got), 32'h10);
    do_read(1'b1, 0, 1'b0, got); check_eq("wrap_mode1", 32'(got), 32'h11);
    check_eq("ptr_wrap_led", 32'(ptr), 32'h01);
    load_ptr(8'hFF);
    do_read(1'b1, 0, 1'b0, got);
    check_eq("ptr_wrap_ff", 32'(ptr), 32'h00);

    // Write-only and reserved addresses read zero
    set_reg('hFA, 8'h55);
    set_reg('h50, 8'hAA);
    load_ptr(8'hFA);
    do_read(1'b1, 0, 1'b0, got); check_eq("all_led_zero", 32'(got), 32'h00);
    load_ptr(8'h50);
    do_read(1'b1, 0, 1'b0, got); check_eq("reserved_zero", 32'(got), 32'h00);

    // LED group coherence
    set_reg('h06, 8'h01);
    set_reg('h07, 8'h02);
    set_reg('h08, 8'h03);
    set_reg('h09, 8'h04);
    load_ptr(8'h06);
    do_read(1'b1, 0, 1'b0, got); check_eq("led0_on_l", 32'(got), 32'h01);
    set_reg('h07, 8'h99);
    do_read(1'b1, 0, 1'b0, got);
`ifdef REGISTER_READER_SNAPSHOT_EN
    check_eq("led0_on_h_snap", 32'(got), 32'h02);
`else
    check_eq("led0_on_h_live", 32'(got), 32'h99);
`endif

    // Pointer load with simultaneous ack in VALID
    load_ptr(8'h10);
    abort_read(1, 8'h20, 1'b1, 1'b0);
    check_eq("abort_no_inc", 32'(ptr), 32'h20);

    // AI=0 keeps the pointer
    load_ptr(8'hFE);
    for (int i = 0; i < 3; i++) begin
      do_read(1'b0, i, 1'b0, got);
      check_eq("prescale", 32'(got), 32'h1E);
    end
    check_eq("ptr_no_ai", 32'(ptr), 32'hFE);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 255));
            1: v = 6 + 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3));
            2: v = int'($urandom_range('h42, 'h47));
            default: v = int'($urandom_range('hF8, 'hFF));
          endcase
          load_ptr(8'(v));
        end
        2: begin
          a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 'h45)) : int'($urandom_range(0, 255));
          set_reg(a, 8'($urandom));
        end
        3: abort_read(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        default: do_read($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), got);
      endcase
    end

    // Asynchronous reset in the middle of FETCH
    load_ptr(8'h07);
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check_eq("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", 32'({rd_data, rd_valid, ptr, busy}), 32'h0);
    m_ptr = 0;
    m_sv = 1'b0;
    m_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(1'b1, 0, 1'b0, got);
    check_eq("post_reset_mode1", 32'(got), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
